idex_debug_stepper: RTL and testbench
=====================================

# idex_debug_stepper

Debug-side controller for the ID/EX pipeline latch. Accepts command bytes from the debug UART receiver, drives the latch's step enable (run / single-step / stop), and reads back the latch contents as a fixed 25-byte frame over a valid/ready byte stream to the UART transmitter. It sits between the UART debug path and the pipeline's stall/step input.

## Interface
Parameters:
- BITS_SIZE, 32, datapath word width
- BITS_REGS, 5, register-index width

Ports:
- i_clk  in  1  clock, single domain
- i_reset  in  1  synchronous, active-high reset
- i_cmd_valid  in  1  command byte present
- i_cmd_data  in  8  command byte
- o_cmd_ready  out  1  command consumed when valid & ready
- o_step  out  1  step enable to the pipeline latches
- i_pc4  in  BITS_SIZE  latch PC+4
- i_instruction  in  BITS_SIZE  latch instruction
- i_register_1  in  BITS_SIZE  latch rs data
- i_register_2  in  BITS_SIZE  latch rt data
- i_extension  in  BITS_SIZE  latch sign-extended immediate
- i_rs, i_rt, i_rd  in  BITS_REGS each  latch register indices
- i_idex_ctrl  in  16  packed latch control, MSB→LSB: jump, jal, alu_src, unit_alu_op[1:0], register_rd_dst, branch, neq_branch, mem_write, mem_read, datamem_size[1:0], mem_to_reg, register_write, lui, halt (bit 0)
- o_tx_valid  out  1  frame byte valid
- o_tx_data  out  8  frame byte
- i_tx_ready  in  1  transmitter accepts byte
- o_busy  out  1  frame in progress
- o_halted  out  1  halt reached

## Operation
- Commands: 0x00 STOP, 0x01 RUN, 0x02 STEP, 0x03 DUMP; any other byte is consumed and ignored.
- States: IDLE, RUN, STEP, SETTLE, SEND, HALTED.
- IDLE: RUN→RUN; STEP→STEP; DUMP→capture, SEND; STOP ignored.
- RUN: o_step = ~i_idex_ctrl[0]. STOP→IDLE. Halt bit seen → capture, SEND, then HALTED.
- STEP: exactly one cycle, o_step=1 → SETTLE (one cycle, o_step=0) → capture, SEND → IDLE, or HALTED if the captured halt bit is 1.
- HALTED: only DUMP acts (capture, SEND, back to HALTED); RUN/STEP/STOP consumed, ignored. Left only via reset.
- o_cmd_ready = 1 in IDLE, RUN, HALTED; 0 in STEP, SETTLE, SEND.
- Capture: snapshot register loads all latch inputs at the edge entering SEND; frame content never tracks live inputs afterwards.
- Frame (25 bytes): 0xA5 header, then words pc4, instruction, register_1, register_2, extension, {1'b0, rs, rt, rd, i_idex_ctrl}; each word MSB byte first.
- SEND: o_tx_valid=1; byte index advances only on o_tx_valid & i_tx_ready; o_tx_data stable while unaccepted. After byte 24 accepted, o_tx_valid=0 next cycle.
- o_busy=1 in SEND only; o_halted=1 in HALTED and in SEND when entered from a halt.

## Timing
- Reset values (state IDLE): o_step 0, o_tx_valid 0, o_tx_data 0x00, o_cmd_ready 1, o_busy 0, o_halted 0, byte index 0.
- o_step combinational from state and i_idex_ctrl[0]; all else registered.
- RUN accepted at edge k: o_step high from cycle k+1; first cycle halt=1 on latch output, o_step=0 that same cycle (latch frozen holding halt), capture at that edge.
- STEP accepted at edge k: o_step high in cycle k+1 only; SETTLE k+2; header valid from k+3.
- Frame at ready=1 continuously: 25 cycles from first valid to last acceptance.
- Reset mid-frame: o_tx_valid 0 next cycle, index cleared; no partial resume.
- Command with valid while ready=0: not consumed, must be held by sender.

## Structure
- Package debug_pkg: command codes, header 0xA5, FRAME_BYTES=25, state enum, ctrl bit positions.
- Sub-module frame_serializer: 200-bit snapshot in, byte index counter, valid/ready byte output, done pulse.

## Test plan
- Reset, latch stub pc4=0x00000004, instruction=0x8C220010, rs=1, rt=2, rd=0, ctrl=0x0000; send 0x02 → o_step high exactly 1 cycle; frame A5 00 00 00 04 8C 22 00 10 …, last word 0x04400000 (rs=1, rt=2, rd=0, ctrl=0x0000).
- Same dump with i_tx_ready low 5 cycles at byte 3 → o_tx_data held, exactly 25 distinct bytes accepted, none skipped.
- 0x01 with halt bit rising after 7 steps → o_step high exactly 7 cycles; frame last byte LSB=1; o_halted=1; later 0x01/0x02 leave o_step 0; 0x03 yields identical frame.
- 0x02 offered during SEND → o_cmd_ready 0, not consumed; accepted in cycle after frame ends.
- Reset at byte 10 → o_tx_valid 0 next cycle; subsequent 0x03 starts at 0xA5.
- 0x7F in IDLE → consumed, no o_step, no frame; 0x00 in RUN → o_step 0 from the next cycle, state IDLE.

Source files
------------

// File: rtl/idex_debug_stepper_pkg.sv
// Shared constants and types for the ID/EX debug stepper: command codes,
// frame layout and controller states.
package debug_pkg;

  localparam logic [7:0] CMD_STOP = 8'h00;
  localparam logic [7:0] CMD_RUN  = 8'h01;
  localparam logic [7:0] CMD_STEP = 8'h02;
  localparam logic [7:0] CMD_DUMP = 8'h03;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam int         FRAME_BYTES  = 25;

  // Halt flag position inside the packed 16-bit ID/EX control word
  localparam int CTRL_HALT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_SETTLE,
    ST_SEND,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/idex_debug_stepper_if.sv
// Debug-side byte streams: command bytes in from the UART receiver and
// frame bytes out to the UART transmitter, both valid/ready.
interface idex_debug_stepper_if;
  logic       i_cmd_valid;
  logic [7:0] i_cmd_data;
  logic       o_cmd_ready;
  logic       o_tx_valid;
  logic [7:0] o_tx_data;
  logic       i_tx_ready;

  modport master (
    output i_cmd_valid, i_cmd_data, i_tx_ready,
    input  o_cmd_ready, o_tx_valid, o_tx_data
  );

  modport slave (
    input  i_cmd_valid, i_cmd_data, i_tx_ready,
    output o_cmd_ready, o_tx_valid, o_tx_data
  );
endinterface

// File: rtl/idex_debug_stepper_frame_serializer.sv
// Holds a captured latch snapshot and streams it MSB byte first over a
// valid/ready byte interface, pulsing o_done on the last accepted byte.
module frame_serializer
  import debug_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_load,
  input  logic [FRAME_BYTES*8-1:0] i_snapshot,
  input  logic                     i_tx_ready,
  output logic                     o_tx_valid,
  output logic [7:0]               o_tx_data,
  output logic                     o_done
);

  localparam int                IDX_W    = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  // Element 0 is the most significant byte, so the index walks the frame in order
  logic [0:FRAME_BYTES-1][7:0] snap_q, snap_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        valid_q, valid_d;

  always_comb begin
    snap_d  = snap_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    o_done  = 1'b0;
    if (i_load) begin
      snap_d  = i_snapshot;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && i_tx_ready) begin
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        valid_d = 1'b0;
        o_done  = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      snap_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_valid = valid_q;
  assign o_tx_data  = valid_q ? snap_q[idx_q] : 8'h00;

endmodule

// File: rtl/idex_debug_stepper.sv
// Debug controller for the ID/EX latch: decodes UART command bytes into
// run / single-step / stop, and dumps a 25-byte latch snapshot on request or halt.
module idex_debug_stepper
  import debug_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  idex_debug_stepper_if.slave  dbg,
  output logic                 o_step,
  input  logic [BITS_SIZE-1:0] i_pc4,
  input  logic [BITS_SIZE-1:0] i_instruction,
  input  logic [BITS_SIZE-1:0] i_register_1,
  input  logic [BITS_SIZE-1:0] i_register_2,
  input  logic [BITS_SIZE-1:0] i_extension,
  input  logic [BITS_REGS-1:0] i_rs,
  input  logic [BITS_REGS-1:0] i_rt,
  input  logic [BITS_REGS-1:0] i_rd,
  input  logic [15:0]          i_idex_ctrl,
  output logic                 o_busy,
  output logic                 o_halted
);

  state_e state_q, state_d;
  logic   send_halt_q, send_halt_d;
  logic   cmd_ready_q, cmd_ready_d;
  logic   busy_q, busy_d;
  logic   halted_q, halted_d;

  logic   cmd_fire;
  logic   halt_seen;
  logic   load;
  logic   frame_done;
  logic [FRAME_BYTES*8-1:0] snapshot;

  assign snapshot = {FRAME_HEADER, i_pc4, i_instruction, i_register_1, i_register_2,
                     i_extension, 1'b0, i_rs, i_rt, i_rd, i_idex_ctrl};

  assign cmd_fire  = dbg.i_cmd_valid & cmd_ready_q;
  assign halt_seen = i_idex_ctrl[CTRL_HALT];

  // In RUN the step enable drops in the same cycle the halt flag shows, freezing the latch on it
  assign o_step = (state_q == ST_STEP) | ((state_q == ST_RUN) & ~halt_seen);

  always_comb begin
    state_d     = state_q;
    send_halt_d = send_halt_q;
    load        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (dbg.i_cmd_data == CMD_RUN) begin
            state_d = ST_RUN;
          end else if (dbg.i_cmd_data == CMD_STEP) begin
            state_d = ST_STEP;
          end else if (dbg.i_cmd_data == CMD_DUMP) begin
            load        = 1'b1;
            send_halt_d = 1'b0;
            state_d     = ST_SEND;
          end
        end
      end
      ST_RUN: begin
        if (halt_seen) begin
          load        = 1'b1;
          send_halt_d = 1'b1;
          state_d     = ST_SEND;
        end else if (cmd_fire && dbg.i_cmd_data == CMD_STOP) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        load        = 1'b1;
        send_halt_d = halt_seen;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (frame_done) begin
          state_d = send_halt_q ? ST_HALTED : ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (cmd_fire && dbg.i_cmd_data == CMD_DUMP) begin
          load        = 1'b1;
          send_halt_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_HALTED);
    busy_d      = (state_d == ST_SEND);
    halted_d    = (state_d == ST_HALTED) || ((state_d == ST_SEND) && send_halt_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      send_halt_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      send_halt_q <= send_halt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign dbg.o_cmd_ready = cmd_ready_q;
  assign o_busy          = busy_q;
  assign o_halted        = halted_q;

  frame_serializer u_serializer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (load),
    .i_snapshot (snapshot),
    .i_tx_ready (dbg.i_tx_ready),
    .o_tx_valid (dbg.o_tx_valid),
    .o_tx_data  (dbg.o_tx_data),
    .o_done     (frame_done)
  );

endmodule

// File: tb/tb_idex_debug_stepper.sv
// Bench for idex_debug_stepper: table vectors, hand-written timing corner
// cases and a randomized command mix checked against a frame/step model.
module tb_idex_debug_stepper;

  typedef struct {
    logic [31:0] pc4, instr, r1, r2, ext;
    logic [4:0]  rs, rt, rd;
    logic [15:0] ctrl;
  } latch_t;

  typedef struct {
    logic [7:0]  cmd;
    latch_t      lat;
    int          exp_steps;
    int          exp_bytes;
    bit          exp_halted;
    logic [31:0] exp_last;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        o_step, o_busy, o_halted;
  logic [31:0] pc4, instr, reg1, reg2, ext;
  logic [4:0]  rs, rt, rd;
  logic [15:0] ctrl;

  idex_debug_stepper_if dbg ();

  idex_debug_stepper #(.BITS_SIZE(32), .BITS_REGS(5)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .dbg           (dbg),
    .o_step        (o_step),
    .i_pc4         (pc4),
    .i_instruction (instr),
    .i_register_1  (reg1),
    .i_register_2  (reg2),
    .i_extension   (ext),
    .i_rs          (rs),
    .i_rt          (rt),
    .i_rd          (rd),
    .i_idex_ctrl   (ctrl),
    .o_busy        (o_busy),
    .o_halted      (o_halted)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] rxq[$];
  int   last_acc_cyc, consume_cyc, steps_seen, stub_steps, halt_after;
  bit   consumed, advance, scramble, rand_ready, held_v;
  bit   s_step, s_busy, s_valid, s_halted, s_cready;
  logic [7:0] s_data, held;
  latch_t cur, nxt, tp;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic latch_t mk_latch(input logic [31:0] p, i, a, b, e,
                                      input logic [4:0] s, t, d, input logic [15:0] c);
    latch_t l;
    l.pc4 = p; l.instr = i; l.r1 = a; l.r2 = b; l.ext = e;
    l.rs = s; l.rt = t; l.rd = d; l.ctrl = c;
    return l;
  endfunction

  function automatic latch_t rand_latch();
    return mk_latch($urandom, $urandom, $urandom, $urandom, $urandom,
                    5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom) & 16'hFFFE);
  endfunction

  // Reference frame: header followed by six 32-bit words, MSB byte first
  function automatic logic [199:0] frame_of(input latch_t l);
    return {8'hA5, l.pc4, l.instr, l.r1, l.r2, l.ext, 1'b0, l.rs, l.rt, l.rd, l.ctrl};
  endfunction

  task automatic apply_latch(input latch_t l);
    pc4 = l.pc4; instr = l.instr; reg1 = l.r1; reg2 = l.r2; ext = l.ext;
    rs = l.rs; rt = l.rt; rd = l.rd; ctrl = l.ctrl;
  endtask

  // One clock: sample at negedge, then update the latch stub just after posedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_step = o_step; s_busy = o_busy; s_valid = dbg.o_tx_valid; s_data = dbg.o_tx_data;
    s_halted = o_halted; s_cready = dbg.o_cmd_ready;
    if (o_step) steps_seen++;
    if (held_v && dbg.o_tx_valid) check_output("tx_data_hold", dbg.o_tx_data, held);
    held_v = dbg.o_tx_valid && !dbg.i_tx_ready;
    held   = dbg.o_tx_data;
    if (dbg.o_tx_valid && dbg.i_tx_ready) begin
      rxq.push_back(dbg.o_tx_data);
      last_acc_cyc = cyc;
    end
    if (dbg.i_cmd_valid && dbg.o_cmd_ready) begin
      consumed = 1'b1;
      consume_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (s_step) begin
      stub_steps++;
      if (advance) begin
        cur = nxt;
        apply_latch(cur);
      end
      if (halt_after > 0 && stub_steps == halt_after) ctrl[0] = 1'b1;
    end
    if (scramble) begin
      if (s_busy) apply_latch(rand_latch());
      else        apply_latch(cur);
    end
    if (rand_ready) dbg.i_tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic apply_stimulus(input logic [7:0] c);
    consumed = 1'b0;
    dbg.i_cmd_valid = 1'b1;
    dbg.i_cmd_data  = c;
    for (int i = 0; i < 100 && !consumed; i++) tick();
    dbg.i_cmd_valid = 1'b0;
    check_output("cmd_consumed", 64'(consumed), 64'd1);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 400 && !(rxq.size() >= 25 && !s_busy); i++) tick();
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_frame(input string name, input latch_t l);
    logic [199:0] f;
    logic [7:0]   b;
    f = frame_of(l);
    check_output({name, "_len"}, 64'(rxq.size()), 64'd25);
    if (rxq.size() == 25) begin
      for (int i = 0; i < 25; i++) begin
        b = f[8*(24-i) +: 8];
        check_output($sformatf("%s_byte%0d", name, i), 64'(rxq[i]), 64'(b));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dbg.i_cmd_valid = 1'b0;
    dbg.i_tx_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rxq.delete();
    steps_seen = 0; stub_steps = 0; held_v = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] lw;
    int a, b, op;
    reset = 1'b1;
    dbg.i_cmd_valid = 1'b0; dbg.i_cmd_data = 8'h00; dbg.i_tx_ready = 1'b1;
    advance = 1'b1; scramble = 1'b0; rand_ready = 1'b0; halt_after = 0;
    tp = mk_latch(32'h00000004, 32'h8C220010, 32'h11111111, 32'h22222222, 32'h00000010,
                  5'd1, 5'd2, 5'd0, 16'h0000);
    cur = tp; nxt = tp; apply_latch(tp);

    // Reset values
    do_reset();
    @(negedge clk);
    check_output("rst_step",   64'(o_step), 64'd0);
    check_output("rst_valid",  64'(dbg.o_tx_valid), 64'd0);
    check_output("rst_data",   64'(dbg.o_tx_data), 64'h00);
    check_output("rst_cready", 64'(dbg.o_cmd_ready), 64'd1);
    check_output("rst_busy",   64'(o_busy), 64'd0);
    check_output("rst_halted", 64'(o_halted), 64'd0);
    @(posedge clk); #1;

    // Table vectors
    vecs[0] = '{8'h02, tp, 1, 25, 1'b0, 32'h04400000};
    vecs[1] = '{8'h03, mk_latch(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D,
                                32'hFFFF8000, 5'd31, 5'd0, 5'd31, 16'h1234),
                0, 25, 1'b0, 32'h7C1F1234};
    vecs[2] = '{8'h7F, tp, 0, 0, 1'b0, 32'h0};
    vecs[3] = '{8'h00, tp, 0, 0, 1'b0, 32'h0};
    vecs[4] = '{8'h02, mk_latch(32'h100, 32'h0000000C, 32'h5, 32'h6, 32'h7,
                                5'd0, 5'd0, 5'd0, 16'h0001),
                1, 25, 1'b1, 32'h00000001};
    vecs[5] = '{8'h01, mk_latch(32'h200, 32'hFC000000, 32'hA, 32'hB, 32'hC,
                                5'd5, 5'd6, 5'd7, 16'h8001),
                0, 25, 1'b1, 32'h14C78001};
    foreach (vecs[v]) begin
      do_reset();
      cur = vecs[v].lat; nxt = vecs[v].lat; apply_latch(cur);
      apply_stimulus(vecs[v].cmd);
      if (vecs[v].exp_bytes > 0) wait_frame();
      else wait_ticks(8);
      wait_ticks(4);
      check_output($sformatf("vec%0d_steps", v), 64'(steps_seen), 64'(vecs[v].exp_steps));
      check_output($sformatf("vec%0d_bytes", v), 64'(rxq.size()), 64'(vecs[v].exp_bytes));
      check_output($sformatf("vec%0d_halted", v), 64'(s_halted), 64'(vecs[v].exp_halted));
      if (vecs[v].exp_bytes > 0 && rxq.size() == 25) begin
        lw = {rxq[21], rxq[22], rxq[23], rxq[24]};
        check_output($sformatf("vec%0d_lastword", v), 64'(lw), 64'(vecs[v].exp_last));
        check_frame($sformatf("vec%0d_frame", v), vecs[v].lat);
      end
    end

    // STEP timing: step high one cycle, one settle cycle, header on the next
    do_reset();
    cur = tp; nxt = tp; apply_latch(tp);
    consumed = 1'b0;
    dbg.i_cmd_valid = 1'b1; dbg.i_cmd_data = 8'h02;
    tick();
    dbg.i_cmd_valid = 1'b0;
    check_output("step_accept", 64'(consumed), 64'd1);
    tick();
    check_output("step_k1", 64'(s_step), 64'd1);
    tick();
    check_output("step_k2", 64'(s_step), 64'd0);
    check_output("settle_valid", 64'(s_valid), 64'd0);
    tick();
    check_output("hdr_valid_k3", 64'(s_valid), 64'd1);
    check_output("hdr_data_k3", 64'(s_data), 64'hA5);
    wait_frame();
    check_frame("step_frame", tp);

    // Backpressure at byte 3 for five cycles
    do_reset();
    apply_stimulus(8'h03);
    for (int i = 0; i < 100 && rxq.size() < 3; i++) tick();
    dbg.i_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("bp_valid", 64'(s_valid), 64'd1);
      check_output("bp_data", 64'(s_data), 64'h00);
    end
    dbg.i_tx_ready = 1'b1;
    wait_frame();
    check_frame("bp_frame", tp);

    // RUN until the halt flag appears after seven steps
    do_reset();
    cur = tp; nxt = tp; apply_latch(tp);
    halt_after = 7;
    apply_stimulus(8'h01);
    wait_frame();
    tick();
    cur.ctrl[0] = 1'b1;
    check_output("run_steps", 64'(steps_seen), 64'd7);
    check_frame("halt_frame", cur);
    check_output("halt_halted", 64'(s_halted), 64'd1);
    halt_after = 0;
    rxq.delete(); steps_seen = 0;
    apply_stimulus(8'h01);
    wait_ticks(5);
    apply_stimulus(8'h02);
    wait_ticks(5);
    check_output("halted_no_step", 64'(steps_seen), 64'd0);
    check_output("halted_no_frame", 64'(rxq.size()), 64'd0);
    apply_stimulus(8'h03);
    wait_frame();
    check_frame("halted_redump", cur);
    tick();
    check_output("halted_stays", 64'(s_halted), 64'd1);

    // Command offered during SEND is held until the cycle after the frame ends
    do_reset();
    cur = tp; nxt = tp; apply_latch(tp);
    apply_stimulus(8'h03);
    wait_ticks(3);
    consumed = 1'b0;
    dbg.i_cmd_valid = 1'b1; dbg.i_cmd_data = 8'h02;
    tick();
    check_output("send_cready", 64'(s_cready), 64'd0);
    for (int i = 0; i < 100 && !consumed; i++) tick();
    dbg.i_cmd_valid = 1'b0;
    check_output("late_cmd_cycle", 64'(consume_cyc), 64'(last_acc_cyc + 1));
    check_frame("late_cmd_frame", tp);
    rxq.delete(); steps_seen = 0;
    wait_frame();
    check_output("late_cmd_steps", 64'(steps_seen), 64'd1);

    // Reset in the middle of a frame
    do_reset();
    apply_stimulus(8'h03);
    for (int i = 0; i < 100 && rxq.size() < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_output("midrst_valid", 64'(s_valid), 64'd0);
    check_output("midrst_busy", 64'(s_busy), 64'd0);
    rxq.delete();
    apply_stimulus(8'h03);
    wait_frame();
    check_frame("after_rst_frame", tp);

    // STOP while running
    do_reset();
    apply_stimulus(8'h01);
    wait_ticks(3);
    apply_stimulus(8'h00);
    tick();
    check_output("stop_step", 64'(s_step), 64'd0);
    check_output("stop_cready", 64'(s_cready), 64'd1);
    steps_seen = 0;
    wait_ticks(5);
    check_output("stop_no_step", 64'(steps_seen), 64'd0);

    // Randomized command mix against the transaction model
    do_reset();
    scramble = 1'b1; rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      cur = rand_latch(); nxt = cur; apply_latch(cur);
      rxq.delete(); steps_seen = 0;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          apply_stimulus(8'h03);
          wait_frame();
          check_frame("rnd_dump", cur);
          check_output("rnd_dump_steps", 64'(steps_seen), 64'd0);
        end
        1: begin
          nxt = rand_latch();
          apply_stimulus(8'h02);
          wait_frame();
          check_frame("rnd_step", nxt);
          check_output("rnd_step_steps", 64'(steps_seen), 64'd1);
        end
        2: begin
          apply_stimulus(8'($urandom_range(4, 255)));
          wait_ticks(6);
          check_output("rnd_junk_bytes", 64'(rxq.size()), 64'd0);
          check_output("rnd_junk_steps", 64'(steps_seen), 64'd0);
        end
        default: begin
          apply_stimulus(8'h01);
          a = consume_cyc;
          wait_ticks($urandom_range(0, 5));
          apply_stimulus(8'h00);
          b = consume_cyc;
          wait_ticks(3);
          check_output("rnd_run_steps", 64'(steps_seen), 64'(b - a));
          check_output("rnd_run_bytes", 64'(rxq.size()), 64'd0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
